// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing constants (640x480@60 defaults), the counter width, and the
// packed layout of the registered output stage. The scan controller and the
// pixel divider import this package.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned CNT_W        = 16;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Everything that leaves the block towards the DAC, registered together
    // so that colour, DE and both syncs share one latency.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
    } vga_out_t;

    // Half-open window test lo <= cnt < hi on unsigned counter values.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_pix_div.sv
// ---------------------------------------------------------------------------
// vga_pix_div
// Pixel clock-enable generator. A counter runs 0..PIX_DIV-1 and wraps; pix_ce
// is high for the single clk in which the counter sits at PIX_DIV-1. With
// PIX_DIV=1 the counter never leaves 0, so pix_ce is permanently high.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   pix_ce out  one-clk pixel enable
// ---------------------------------------------------------------------------
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_ce
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(PIX_DIV - 1);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;

    assign pix_ce = (div_q == DIV_LAST);

    always_comb begin
        div_d = pix_ce ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule : vga_pix_div

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
// VGA raster scan controller. Horizontal/vertical counters advance on the
// pixel enable; (x,y) are presented to an external pixel source which returns
// a colour combinationally. The colour is blanked outside the active region
// and registered together with DE, HSYNC and VSYNC, so all DAC-side outputs
// lag (x,y) by exactly one pixel.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   x, y                  current h/v count (zero-extended) to the pixel source
//   r_in, g_in, b_in      colour for (x,y), combinational from the source
//   vga_r/g/b             registered colour to the DAC
//   vga_hs, vga_vs        sync outputs, asserted level SYNC_ACT
//   vga_de                active-video flag aligned with the colour
//   line_tick             one-clk pulse on the last pixel of each line
//   vblank_tick           one-clk pulse on the last pixel of the last active line
// ---------------------------------------------------------------------------
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_ACT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] x,
    output logic [15:0] y,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        line_tick,
    output logic        vblank_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_BEG     = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG     = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam vga_out_t OUT_RST = '{r: 8'h00, g: 8'h00, b: 8'h00,
                                     de: 1'b0, hs: ~SYNC_ACT, vs: ~SYNC_ACT};

    logic             pix_ce;
    logic             h_wrap;
    logic             active;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    vga_out_t         out_q, out_d;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce)
    );

    // Last pixel of a line: both tick outputs are decoded from this so they
    // last exactly one clk (the pix_ce clk) and drop immediately on reset.
    assign h_wrap = pix_ce && (h_cnt_q == H_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);

    // Output stage: colour is forced to zero in blanking so that whatever the
    // pixel source returns there never reaches the DAC.
    always_comb begin
        out_d    = out_q;
        out_d.r  = active ? r_in : 8'h00;
        out_d.g  = active ? g_in : 8'h00;
        out_d.b  = active ? b_in : 8'h00;
        out_d.de = active;
        out_d.hs = in_window(h_cnt_q, HS_BEG, HS_END) ? SYNC_ACT : ~SYNC_ACT;
        out_d.vs = in_window(v_cnt_q, VS_BEG, VS_END) ? SYNC_ACT : ~SYNC_ACT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= OUT_RST;
        end else if (pix_ce) begin
            out_q <= out_d;
        end
    end

    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign vga_r       = out_q.r;
    assign vga_g       = out_q.g;
    assign vga_b       = out_q.b;
    assign vga_de      = out_q.de;
    assign vga_hs      = out_q.hs;
    assign vga_vs      = out_q.vs;
    assign line_tick   = h_wrap;
    assign vblank_tick = h_wrap && (v_cnt_q == V_ACT_LAST);

endmodule : vga_scan_ctrl

// File: tb/tb_vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_ctrl
// Scaled-down raster (16x11 total, 8x6 active) so several frames fit in a
// short run. Main instance uses PIX_DIV=2; a second instance with PIX_DIV=1
// shares clock and reset. Expected DAC words are queued when a pixel enable
// is due and popped one pixel later when the DUT registers them.
// ---------------------------------------------------------------------------
module tb_vga_scan_ctrl;

    localparam int PD = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 11
    localparam int FRAME = HT * VT * PD;     // clks per frame
    localparam bit SA = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x, y;
    logic [7:0]  r_in, g_in, b_in;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, line_tick, vblank_tick;

    logic [15:0] x1, y1;
    logic [7:0]  r1, g1, b1;
    logic [7:0]  vga_r1, vga_g1, vga_b1;
    logic        vga_hs1, vga_vs1, vga_de1, line_tick1, vblank_tick1;

    logic        mode;
    int          vectors = 0;
    int          miscompares = 0;

    // bench reference model
    int          hm, vm, dm, c1, cyc;
    logic [26:0] exp_out;
    logic [26:0] sb[$];
    int          n_line, n_vblank, n_hs, n_vs, n_de, n_rff0, n_rff1;

    localparam logic [26:0] RST_OUT = {24'h0, 1'b0, ~SA, ~SA};

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(SA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .line_tick(line_tick), .vblank_tick(vblank_tick)
    );

    vga_scan_ctrl #(
        .PIX_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(SA)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1),
        .r_in(r1), .g_in(g1), .b_in(b1),
        .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1),
        .vga_hs(vga_hs1), .vga_vs(vga_vs1), .vga_de(vga_de1),
        .line_tick(line_tick1), .vblank_tick(vblank_tick1)
    );

    // Pixel source: answers combinationally for the DUT's (x,y).
    always_comb begin
        if (mode == 1'b0) begin
            r_in = (x == 16'd0) ? 8'hFF : 8'h00;
            g_in = x[7:0] + 8'h11;
            b_in = y[7:0] ^ 8'hA5;
        end else begin
            r_in = 8'hFF;
            g_in = 8'hFF;
            b_in = 8'hFF;
        end
    end

    function automatic logic [26:0] exp_px(input logic m, input int h, input int v);
        logic act, hsa, vsa;
        logic [7:0] r, g, b;
        act = (h < HA) && (v < VA);
        hsa = (h >= HA + HF) && (h < HA + HF + HS);
        vsa = (v >= VA + VF) && (v < VA + VF + VS);
        if (m == 1'b0) begin
            r = (h == 0) ? 8'hFF : 8'h00;
            g = 8'(h) + 8'h11;
            b = 8'(v) ^ 8'hA5;
        end else begin
            r = 8'hFF; g = 8'hFF; b = 8'hFF;
        end
        if (!act) begin
            r = 8'h00; g = 8'h00; b = 8'h00;
        end
        return {r, g, b, act, hsa ? SA : ~SA, vsa ? SA : ~SA};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [26:0] dac_word();
        return {vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs};
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_dac"}, 32'(dac_word()), 32'(RST_OUT));
        chk({tag, "_ticks"}, {30'd0, line_tick, vblank_tick}, 0);
        chk({tag, "_x1"}, 32'(x1), 0);
    endtask

    task automatic model_reset();
        hm = 0; vm = 0; dm = 0; c1 = 0; cyc = 0;
        exp_out = RST_OUT;
        sb.delete();
    endtask

    // One clk. Entered and left at a falling edge.
    task automatic step();
        logic ce;
        ce = (dm == PD - 1);
        chk("x", 32'(x), 32'(hm));
        chk("y", 32'(y), 32'(vm));
        chk("line_tick", 32'(line_tick), 32'(ce && hm == HT - 1));
        chk("vblank_tick", 32'(vblank_tick), 32'(ce && hm == HT - 1 && vm == VA - 1));
        chk("dac_hold", 32'(dac_word()), 32'(exp_out));
        chk("x1", 32'(x1), 32'(c1 % HT));
        chk("y1", 32'(y1), 32'((c1 / HT) % VT));
        chk("line_tick1", 32'(line_tick1), 32'(c1 % HT == HT - 1));
        if (line_tick)   n_line++;
        if (vblank_tick) n_vblank++;
        if (ce) sb.push_back(exp_px(mode, hm, vm));
        @(posedge clk);
        if (ce) begin
            dm = 0;
            if (hm == HT - 1) begin
                hm = 0;
                vm = (vm == VT - 1) ? 0 : vm + 1;
            end else begin
                hm++;
            end
        end else begin
            dm++;
        end
        c1++;
        #1;
        if (ce) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_out = sb.pop_front();
                chk("dac_new", 32'(dac_word()), 32'(exp_out));
                if (vga_hs == SA) n_hs++;
                if (vga_vs == SA) n_vs++;
                if (vga_de) n_de++;
                if (vga_r == 8'hFF && cyc < FRAME)  n_rff0++;
                if (vga_r == 8'hFF && cyc >= FRAME) n_rff1++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        mode  = 1'b0;
        r1 = 8'h5A; g1 = 8'hA5; b1 = 8'h3C;
        n_line = 0; n_vblank = 0; n_hs = 0; n_vs = 0; n_de = 0; n_rff0 = 0; n_rff1 = 0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");

        // Three free-running frames: frame 0 marks x==0 in red, frames 1-2
        // hold the source at full white to prove blanking.
        rst_n = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            mode = (i >= FRAME);
            step();
        end
        chk("vblank_count", 32'(n_vblank), 3);
        chk("line_count", 32'(n_line), 3 * VT);
        chk("hs_pixels", 32'(n_hs), 3 * VT * HS);
        chk("vs_pixels", 32'(n_vs), 3 * HT * VS);
        chk("de_pixels", 32'(n_de), 3 * HA * VA);
        chk("r_ff_frame0", 32'(n_rff0), VA);
        chk("r_ff_white", 32'(n_rff1), 2 * HA * VA);

        // Asynchronous reset in the middle of a frame, between clock edges.
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            if (hm == 5 && vm == 3) found = 1'b1;
            else step();
        end
        chk("find_mid_frame", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async_reset");

        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * HT * PD; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule : tb_vga_scan_ctrl

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  PIX_DIV 2, clk cycles per pixel (>=1)
  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48, horizontal timing in pixels
  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33, vertical timing in lines
  SYNC_ACT 0, asserted level of vga_hs/vga_vs
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single system clock
  rst_n  in  1  asynchronous active-low reset
  x  out  16  current horizontal pixel count, to the pixel source
  y  out  16  current vertical line count, to the pixel source
  r_in, g_in, b_in  in  8 each  pixel colour returned combinationally for (x,y)
  vga_r, vga_g, vga_b  out  8 each  registered colour to DAC
  vga_hs, vga_vs  out  1  sync outputs
  vga_de  out  1  active-video flag aligned with vga_rgb
  line_tick  out  1  one-clk pulse at end of each line
  vblank_tick  out  1  one-clk pulse on entry to vertical blank; game-update clock
REQ-003 The block SHALL use one clock (clk) and an asynchronous active-low reset (rst_n); there SHALL be no other clock domains.

Function
REQ-004 A divider counter SHALL count 0..PIX_DIV-1 and wrap; pix_ce SHALL be high for the one clk where the counter equals PIX_DIV-1; PIX_DIV=1 SHALL make pix_ce permanently high.
REQ-005 h_cnt SHALL advance only on pix_ce, range 0..H_TOTAL-1 (H_TOTAL=800 by default), wrapping to 0.
REQ-006 v_cnt SHALL advance on pix_ce when h_cnt wraps, range 0..V_TOTAL-1 (525 by default), wrapping to 0 at the same edge as h_cnt wraps from 799.
REQ-007 x and y SHALL equal h_cnt and v_cnt directly (zero-extended to 16 bits), including during blanking.
REQ-008 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-009 hsync SHALL be asserted (SYNC_ACT) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751). vsync SHALL be asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-010 On each pix_ce the output stage SHALL register vga_rgb <= active ? {r_in,g_in,b_in} : 0, together with vga_de, vga_hs and vga_vs computed from the same h_cnt/v_cnt; all outputs SHALL carry an identical 1-pixel latency and hold between pix_ce pulses.
REQ-011 line_tick SHALL pulse for exactly one clk when pix_ce is high and h_cnt==H_TOTAL-1.
REQ-012 vblank_tick SHALL pulse for exactly one clk when pix_ce is high, h_cnt==H_TOTAL-1 and v_cnt==V_ACTIVE-1, i.e. once per frame.
REQ-013 Colour inputs outside the active region SHALL never reach vga_rgb.
REQ-014 All counter widths SHALL be 16 bits; comparisons SHALL be unsigned.

Reset
REQ-015 While rst_n is low: divider, h_cnt and v_cnt = 0; vga_rgb = 0; vga_de = 0; vga_hs = vga_vs = ~SYNC_ACT; line_tick = vblank_tick = 0.
REQ-016 Reset asserted mid-frame SHALL take effect immediately, without a clock edge; after deassertion, the first pix_ce SHALL occur PIX_DIV clks after the first rising edge.

Structure
REQ-017 A shared package vga_timing_pkg SHALL hold the default timing constants and the derived H_TOTAL/V_TOTAL; the module parameters SHALL default to these constants.
REQ-018 The pixel-enable divider SHALL be a sub-module named vga_pix_div (ports clk, rst_n, pix_ce).

Verification
REQ-019 Reset then free-run with PIX_DIV=2 -> pix_ce every 2nd clk; h_cnt wraps 799->0 every 1600 clks; v_cnt wraps 524->0 every 840000 clks.
REQ-020 Count hsync over one line -> asserted for exactly 96 pixels starting at h_cnt 656; vsync over one frame -> asserted for 2 lines at v_cnt 490-491.
REQ-021 Drive r_in=8'hFF when x==0 and 0 otherwise -> vga_r=FF for exactly one pixel, one pixel after x==0, with vga_de=1; with r_in held at FF, vga_r=0 at h_cnt>=640 and v_cnt>=480.
REQ-022 Over 3 frames -> vblank_tick pulses exactly 3 times, each one clk wide, when pix_ce is high with h_cnt=799 and v_cnt=479; line_tick pulses 525 times per frame.
REQ-023 Assert rst_n low at h_cnt=300, v_cnt=200, asynchronously to clk -> outputs reach their REQ-015 values before the next clk edge; after release, x=y=0.
REQ-024 PIX_DIV=1 -> pix_ce constantly high; one line = 800 clks.
